// File: rtl/tag_mem_assoc_if.sv
// Request/response bundle between the cache controller and the N-way tag store.
// The controller drives requests through the master modport; the tag store answers through the slave modport.
interface tag_mem_assoc_if #(
  parameter int INDEX_LENGTH = 5,
  parameter int TAG_LENGTH   = 20,
  parameter int NUM_WAYS     = 2
);
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic                    lookup_valid;
  logic [INDEX_LENGTH-1:0] lookup_index;
  logic [TAG_LENGTH-1:0]   lookup_tag;
  logic                    result_valid;
  logic                    hit;
  logic [WAY_BITS-1:0]     hit_way;
  logic [WAY_BITS-1:0]     victim_way;
  logic                    victim_valid;
  logic                    victim_dirty;
  logic [TAG_LENGTH-1:0]   victim_tag;
  logic                    wr_en;
  logic [INDEX_LENGTH-1:0] wr_index;
  logic [WAY_BITS-1:0]     wr_way;
  logic [TAG_LENGTH-1:0]   wr_tag;
  logic                    wr_dirty;
  logic                    mk_dirty_en;
  logic [INDEX_LENGTH-1:0] mk_dirty_index;
  logic [WAY_BITS-1:0]     mk_dirty_way;
  logic                    flush_req;
  logic                    busy;
  logic                    flush_done;

  modport master (
    output lookup_valid, lookup_index, lookup_tag,
    output wr_en, wr_index, wr_way, wr_tag, wr_dirty,
    output mk_dirty_en, mk_dirty_index, mk_dirty_way,
    output flush_req,
    input  result_valid, hit, hit_way,
    input  victim_way, victim_valid, victim_dirty, victim_tag,
    input  busy, flush_done
  );

  modport slave (
    input  lookup_valid, lookup_index, lookup_tag,
    input  wr_en, wr_index, wr_way, wr_tag, wr_dirty,
    input  mk_dirty_en, mk_dirty_index, mk_dirty_way,
    input  flush_req,
    output result_valid, hit, hit_way,
    output victim_way, victim_valid, victim_dirty, victim_tag,
    output busy, flush_done
  );
endinterface

// File: rtl/tag_mem_assoc.sv
// N-way set-associative tag store: registered hit/miss lookup with victim choice
// (first invalid way, else per-set round-robin) and a one-set-per-cycle flush sweep.
module tag_mem_assoc #(
  parameter int INDEX_LENGTH = 5,
  parameter int TAG_LENGTH   = 20,
  parameter int NUM_WAYS     = 2
) (
  input  logic           clk,
  input  logic           resetn,
  tag_mem_assoc_if.slave bus
);
  localparam int NUM_SETS = 2 ** INDEX_LENGTH;
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic [INDEX_LENGTH-1:0] flush_cnt, flush_cnt_nxt;
  logic                    flush_last;

  logic [TAG_LENGTH-1:0]   tag_mem   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]     valid_mem [NUM_SETS];
  logic [NUM_WAYS-1:0]     dirty_mem [NUM_SETS];
  logic [WAY_BITS-1:0]     rr_mem    [NUM_SETS];

  logic                    idle, lookup_act, wr_act, mkd_act;
  logic [WAY_BITS-1:0]     rr_next;

  logic [NUM_WAYS-1:0]     set_valid, set_dirty;
  logic                    hit_p0;
  logic [WAY_BITS-1:0]     hit_way_p0, victim_way_p0;
  logic                    victim_valid_p0, victim_dirty_p0;
  logic [TAG_LENGTH-1:0]   victim_tag_p0;

  logic                    vld_p1, hit_p1;
  logic [WAY_BITS-1:0]     hit_way_p1, victim_way_p1;
  logic                    victim_valid_p1, victim_dirty_p1;
  logic [TAG_LENGTH-1:0]   victim_tag_p1;

  assign idle       = (state == IDLE);
  assign lookup_act = idle & bus.lookup_valid;
  assign wr_act     = idle & bus.wr_en;
  assign mkd_act    = idle & bus.mk_dirty_en;
  assign flush_last = (state == FLUSH) && (flush_cnt == INDEX_LENGTH'(NUM_SETS - 1));
  assign rr_next    = (NUM_WAYS > 1) ? WAY_BITS'(bus.wr_way + 1'b1) : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    bus.busy       = 1'b0;
    bus.flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.flush_req) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      FLUSH: begin
        bus.busy       = 1'b1;
        bus.flush_done = flush_last;
        flush_cnt_nxt  = flush_cnt + 1'b1;
        if (flush_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Valid/dirty/rr state; mk_dirty is applied first so a same-entry wr_en overrides it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        rr_mem[s]    <= '0;
      end
    end else if (state == FLUSH) begin
      valid_mem[flush_cnt] <= '0;
      dirty_mem[flush_cnt] <= '0;
      rr_mem[flush_cnt]    <= '0;
    end else begin
      if (mkd_act && valid_mem[bus.mk_dirty_index][bus.mk_dirty_way])
        dirty_mem[bus.mk_dirty_index][bus.mk_dirty_way] <= 1'b1;
      if (wr_act) begin
        valid_mem[bus.wr_index][bus.wr_way] <= 1'b1;
        dirty_mem[bus.wr_index][bus.wr_way] <= bus.wr_dirty;
        rr_mem[bus.wr_index]                <= rr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_act) tag_mem[bus.wr_index][bus.wr_way] <= bus.wr_tag;
  end

  // Stage p0: compare against pre-write contents of the addressed set.
  always_comb begin
    set_valid     = valid_mem[bus.lookup_index];
    set_dirty     = dirty_mem[bus.lookup_index];
    hit_p0        = 1'b0;
    hit_way_p0    = '0;
    victim_way_p0 = (NUM_WAYS > 1) ? rr_mem[bus.lookup_index] : '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (set_valid[w] && (tag_mem[bus.lookup_index][w] == bus.lookup_tag)) begin
        hit_p0     = 1'b1;
        hit_way_p0 = WAY_BITS'(w);
      end
      if (!set_valid[w]) victim_way_p0 = WAY_BITS'(w);
    end
    victim_valid_p0 = set_valid[victim_way_p0];
    victim_dirty_p0 = set_dirty[victim_way_p0];
    victim_tag_p0   = tag_mem[bus.lookup_index][victim_way_p0];
  end

  // Stage p1: registered results, held between lookups.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1          <= 1'b0;
      hit_p1          <= 1'b0;
      hit_way_p1      <= '0;
      victim_way_p1   <= '0;
      victim_valid_p1 <= 1'b0;
      victim_dirty_p1 <= 1'b0;
      victim_tag_p1   <= '0;
    end else begin
      vld_p1 <= lookup_act;
      if (lookup_act) begin
        hit_p1          <= hit_p0;
        hit_way_p1      <= hit_way_p0;
        victim_way_p1   <= victim_way_p0;
        victim_valid_p1 <= victim_valid_p0;
        victim_dirty_p1 <= victim_dirty_p0;
        victim_tag_p1   <= victim_tag_p0;
      end
    end
  end

  assign bus.result_valid = vld_p1;
  assign bus.hit          = hit_p1;
  assign bus.hit_way      = hit_way_p1;
  assign bus.victim_way   = victim_way_p1;
  assign bus.victim_valid = victim_valid_p1;
  assign bus.victim_dirty = victim_dirty_p1;
  assign bus.victim_tag   = victim_tag_p1;
endmodule

// File: tb/tb_tag_mem_assoc.sv
// Randomised and directed bench for tag_mem_assoc against a per-(set, way) table model.
module tb_tag_mem_assoc;
  localparam int IL = 5;
  localparam int TL = 20;
  localparam int NW = 2;
  localparam int NS = 2 ** IL;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tag_mem_assoc_if #(.INDEX_LENGTH(IL), .TAG_LENGTH(TL), .NUM_WAYS(NW)) bus ();
  tag_mem_assoc #(.INDEX_LENGTH(IL), .TAG_LENGTH(TL), .NUM_WAYS(NW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  bit          m_valid [NS][NW];
  bit          m_dirty [NS][NW];
  logic [TL-1:0] m_tag [NS][NW];
  int          m_rr [NS];
  bit          m_busy;
  int          m_cnt;

  bit          e_hit, e_vvalid, e_vdirty;
  int          e_hit_way, e_vway;
  logic [TL-1:0] e_vtag;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.lookup_valid = 0; bus.lookup_index = '0; bus.lookup_tag = '0;
    bus.wr_en = 0; bus.wr_index = '0; bus.wr_way = '0; bus.wr_tag = '0; bus.wr_dirty = 0;
    bus.mk_dirty_en = 0; bus.mk_dirty_index = '0; bus.mk_dirty_way = '0;
    bus.flush_req = 0;
  endtask

  task automatic set_lookup(input int idx, input int tag);
    bus.lookup_valid = 1; bus.lookup_index = IL'(idx); bus.lookup_tag = TL'(tag);
  endtask

  task automatic set_wr(input int idx, input int way, input int tag, input bit d);
    bus.wr_en = 1; bus.wr_index = IL'(idx); bus.wr_way = 1'(way);
    bus.wr_tag = TL'(tag); bus.wr_dirty = d;
  endtask

  task automatic set_mkd(input int idx, input int way);
    bus.mk_dirty_en = 1; bus.mk_dirty_index = IL'(idx); bus.mk_dirty_way = 1'(way);
  endtask

  // Apply the rules for one clock edge to the model, then compare outputs after the edge.
  task automatic tick();
    bit acc;
    int li, vw, wi, ww, mi, mw;
    acc = 0;
    if (!resetn) begin
      for (int s = 0; s < NS; s++) begin
        m_rr[s] = 0;
        for (int w = 0; w < NW; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
      end
      m_busy = 0; m_cnt = 0;
      e_hit = 0; e_hit_way = 0; e_vway = 0; e_vvalid = 0; e_vdirty = 0; e_vtag = '0;
    end else if (m_busy) begin
      m_rr[m_cnt] = 0;
      for (int w = 0; w < NW; w++) begin m_valid[m_cnt][w] = 0; m_dirty[m_cnt][w] = 0; end
      if (m_cnt == NS - 1) m_busy = 0;
      else m_cnt++;
    end else begin
      if (bus.lookup_valid) begin
        acc = 1;
        li = int'(bus.lookup_index);
        e_hit = 0; e_hit_way = 0;
        for (int w = NW - 1; w >= 0; w--)
          if (m_valid[li][w] && m_tag[li][w] == bus.lookup_tag) begin e_hit = 1; e_hit_way = w; end
        vw = m_rr[li];
        for (int w = NW - 1; w >= 0; w--) if (!m_valid[li][w]) vw = w;
        e_vway = vw; e_vvalid = m_valid[li][vw]; e_vdirty = m_dirty[li][vw]; e_vtag = m_tag[li][vw];
      end
      if (bus.mk_dirty_en) begin
        mi = int'(bus.mk_dirty_index); mw = int'(bus.mk_dirty_way);
        if (m_valid[mi][mw]) m_dirty[mi][mw] = 1;
      end
      if (bus.wr_en) begin
        wi = int'(bus.wr_index); ww = int'(bus.wr_way);
        m_valid[wi][ww] = 1; m_dirty[wi][ww] = bus.wr_dirty; m_tag[wi][ww] = bus.wr_tag;
        m_rr[wi] = (ww + 1) % NW;
      end
      if (bus.flush_req) begin m_busy = 1; m_cnt = 0; end
    end
    @(posedge clk);
    #1;
    clear_inputs();
    check_val("result_valid", 32'(bus.result_valid), 32'(acc));
    check_val("hit", 32'(bus.hit), 32'(e_hit));
    if (e_hit) check_val("hit_way", 32'(bus.hit_way), 32'(e_hit_way));
    check_val("victim_way", 32'(bus.victim_way), 32'(e_vway));
    check_val("victim_valid", 32'(bus.victim_valid), 32'(e_vvalid));
    check_val("victim_dirty", 32'(bus.victim_dirty), 32'(e_vdirty));
    if (e_vvalid) check_val("victim_tag", 32'(bus.victim_tag), 32'(e_vtag));
    check_val("busy", 32'(bus.busy), 32'(m_busy));
    check_val("flush_done", 32'(bus.flush_done), 32'(m_busy && m_cnt == NS - 1));
  endtask

  initial begin
    clear_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;

    // Lookup into an empty set, then allocate and re-lookup.
    set_lookup(3, 'h12345); tick();
    set_wr(3, 0, 'h12345, 0); tick();
    set_lookup(3, 'h12345); tick();
    set_lookup(3, 'h00001); tick();

    // Full set, victim chosen by round-robin pointer.
    set_wr(7, 0, 'hA, 0); tick();
    set_wr(7, 1, 'hB, 0); tick();
    set_mkd(7, 1); tick();
    set_lookup(7, 'hC); tick();
    set_lookup(7, 'hB); tick();
    set_mkd(7, 0); set_wr(7, 0, 'hD, 0); tick();
    set_lookup(7, 'hD); tick();

    // Read-before-write on the same set.
    set_wr(4, 0, 'h55, 1); set_lookup(4, 'h55); tick();
    set_lookup(4, 'h55); tick();

    // Fill several sets, then flush with lookups/writes presented while busy.
    for (int s = 0; s < 8; s++) begin
      set_wr(s * 3 % NS, s % 2, 'h100 + s, s[0]); tick();
    end
    bus.flush_req = 1; tick();
    for (int i = 0; i < NS; i++) begin
      set_lookup(i, 'h100 + i); set_wr(i, 1, 'h777, 1); bus.flush_req = 1; tick();
    end
    for (int s = 0; s < NS; s++) begin set_lookup(s, 'h100 + s); tick(); end

    // Reset in the middle of a flush.
    for (int s = 0; s < 6; s++) begin set_wr(s + 10, 1, 'h200 + s, 1); tick(); end
    bus.flush_req = 1; tick();
    for (int i = 0; i < 9; i++) tick();
    resetn = 0; tick();
    resetn = 1;
    for (int i = 0; i < 3; i++) tick();
    for (int s = 0; s < NS; s++) begin set_lookup(s, 'h200 + s - 10); tick(); end

    // Random traffic on a few sets with a small tag alphabet.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 7) set_lookup($urandom_range(0, 3), $urandom_range(0, 5));
      if ($urandom_range(0, 9) < 3)
        set_wr($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) < 2) set_mkd($urandom_range(0, 3), $urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) bus.flush_req = 1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
